elastic_pipeline: RTL

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

---
 rtl/elastic_pipeline_pkg.sv | 14 +
 rtl/elastic_stage.sv | 38 +++
 rtl/elastic_pipeline.sv | 106 ++++++++++
 3 files changed

// File: rtl/elastic_pipeline_pkg.sv
// Shared defaults and helpers for the elastic increment/multiply pipeline.
package elastic_pipeline_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_INC   = 1;
   localparam int DEF_MUL   = 2;

   // Counter must represent 0..DEPTH+1 (every increment stage plus the output register).
   function automatic int occ_width(input int depth);
      return $clog2(depth + 2);
   endfunction

endpackage

// File: rtl/elastic_stage.sv
// One increment register of the pipeline: loads upstream data + INC whenever its ready is high.
module elastic_stage
   import elastic_pipeline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int INC   = DEF_INC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_ready,
   input  logic             i_up_valid,
   input  logic [WIDTH-1:0] i_up_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_ready) begin
         r_valid <= i_up_valid;
         if (i_up_valid) r_data <= i_up_data + INC_W;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic pipeline: DEPTH increment stages then a multiply output register, valid/ready handshake.
// Define ELASTIC_PIPELINE_OCCUPANCY_EN to add the occupancy port and its counter.
module elastic_pipeline
   import elastic_pipeline_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int INC   = DEF_INC,
   parameter int MUL   = DEF_MUL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

   localparam logic [WIDTH-1:0] MUL_W = WIDTH'(MUL);

   // Index 0 is the upstream interface; index i+1 is the output of stage i.
   logic [DEPTH:0]            w_vld;
   logic [DEPTH:0][WIDTH-1:0] w_data;
   // w_ready[i] is the load enable of stage i; w_ready[DEPTH] belongs to the output register.
   logic [DEPTH:0]            w_ready;

   logic                      r_out_valid;
   logic [WIDTH-1:0]          r_out_data;

   assign w_vld[0]  = in_valid;
   assign w_data[0] = in_data;

   always_comb begin
      w_ready        = '0;
      w_ready[DEPTH] = !r_out_valid || out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_ready[i] = !w_vld[i+1] || w_ready[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      elastic_stage #(
         .WIDTH (WIDTH),
         .INC   (INC)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .i_flush    (flush),
         .i_ready    (w_ready[i]),
         .i_up_valid (w_vld[i]),
         .i_up_data  (w_data[i]),
         .o_valid    (w_vld[i+1]),
         .o_data     (w_data[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_ready[DEPTH]) begin
         r_out_valid <= w_vld[DEPTH];
         if (w_vld[DEPTH]) r_out_data <= w_data[DEPTH] * MUL_W;
      end
   end

   // Reset and flush mask the handshake combinationally so nothing is accepted in those cycles.
   assign in_ready  = w_ready[0] && !flush && !rst;
   assign out_valid = r_out_valid && !rst;
   assign out_data  = rst ? '0 : r_out_data;

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
   localparam int OCC_W = occ_width(DEPTH);

   logic             w_accept;
   logic             w_emit;
   logic [OCC_W-1:0] r_occ;

   assign w_accept = in_valid && in_ready;
   assign w_emit   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_occ <= '0;
      end else if (w_accept && !w_emit) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_accept && w_emit) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign occupancy = r_occ;
`else
   // Occupancy tracking is not built in this configuration.
`endif

endmodule
